// File: rtl/nios_pio_gen.sv
// rtl/nios_pio_gen.sv - Avalon-MM general-purpose I/O with per-bit direction, edge capture and irq
// Optional macro NIOS_PIO_BITSET_EN adds OUTSET (addr 4) / OUTCLEAR (addr 5) write-only registers.
module nios_pio_gen #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] cap_clear;
  logic [2:0]       warm_cnt;
  logic             capture_en;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wr_data      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign in_sync      = sync_q[SYNC_STAGES-1];
  assign capture_en   = (warm_cnt == WARM_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      in_prev <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
      in_prev <= in_sync;
    end
  end

  // Holds off capture until reset-time zeros have flushed out of the synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warm_cnt <= '0;
    end else if (!capture_en) begin
      warm_cnt <= warm_cnt + 3'd1;
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = in_sync & ~in_prev;
      1:       edge_det = ~in_sync & in_prev;
      default: edge_det = in_sync ^ in_prev;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
    end else if (wr_en) begin
      case (address)
        3'd0:    data_out <= wr_data;
`ifdef NIOS_PIO_BITSET_EN
        3'd4:    data_out <= data_out | wr_data;
        3'd5:    data_out <= data_out & ~wr_data;
`endif
        default: data_out <= data_out;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir     <= '0;
      irqmask <= '0;
    end else if (wr_en) begin
      if (address == 3'd1) dir <= wr_data;
      if (address == 3'd2) irqmask <= wr_data;
    end
  end

  assign cap_clear = (wr_en && address == 3'd3) ? wr_data : '0;

  // A fresh edge overrides a simultaneous software clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
    end else begin
      edgecap <= (edgecap & ~cap_clear) | (capture_en ? edge_det : '0);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
      3'd1:    readdata[WIDTH-1:0] = dir;
      3'd2:    readdata[WIDTH-1:0] = irqmask;
      3'd3:    readdata[WIDTH-1:0] = edgecap;
      default: readdata = '0;
    endcase
  end

  assign out_port = data_out;
  assign oe_port  = dir;
  assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_pio_gen.sv
// tb/tb_nios_pio_gen.sv - directed and randomized bench for nios_pio_gen against a pin-history model
module tb_nios_pio_gen;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe_port;
  logic        irq;

  int nvec = 0;
  int nerr = 0;

  // Model: register values plus the history of pin values seen at each clock edge.
  logic [7:0] m_data, m_dir, m_mask, m_cap;
  logic [7:0] hist[$];
  int         ncyc;

  nios_pio_gen #(
    .WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(S), .RESET_VALUE(8'hA5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe_port(oe_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_data = 8'hA5;
    m_dir  = 8'h00;
    m_mask = 8'h00;
    m_cap  = 8'h00;
    hist   = {};
    repeat (S + 2) hist.push_front(8'h00);
    ncyc   = 0;
  endtask

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, (m_dir & m_data) | (~m_dir & hist[S-1])};
      3'd1:    return {24'h0, m_dir};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, m_cap};
      default: return 32'h0;
    endcase
  endfunction

  // A pin transition lands in edgecap S+1 edges later; the first S+1 edges after reset capture nothing.
  task automatic tick();
    logic [7:0] e, clr;
    ncyc++;
    e   = (ncyc >= S + 2) ? (hist[S-1] & ~hist[S]) : 8'h00;
    clr = 8'h00;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data = writedata[7:0];
        3'd1: m_dir  = writedata[7:0];
        3'd2: m_mask = writedata[7:0];
        3'd3: clr    = writedata[7:0];
`ifdef NIOS_PIO_BITSET_EN
        3'd4: m_data = m_data | writedata[7:0];
        3'd5: m_data = m_data & ~writedata[7:0];
`endif
        default: ;
      endcase
    end
    m_cap = (m_cap & ~clr) | e;
    hist.push_front(in_port);
    if (hist.size() > S + 3) void'(hist.pop_back());
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_reset();
    chipselect = 1'b0;
    write_n    = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    in_port = 8'h3C;
    address = 3'd0;
    do_reset();
    nvec++; if (out_port !== 8'hA5) begin nerr++; $display("FAIL reset_out_port: got %h expected a5", out_port); end
    nvec++; if (oe_port !== 8'h00) begin nerr++; $display("FAIL reset_oe_port: got %h expected 00", oe_port); end
    nvec++; if (irq !== 1'b0) begin nerr++; $display("FAIL reset_irq: got %b expected 0", irq); end
    tick(); tick();
    nvec++; if (readdata !== 32'h0000003C || readdata !== exp_read(3'd0))
      begin nerr++; $display("FAIL reset_read_data: got %h expected 0000003c", readdata); end
  endtask

  task automatic test_data_dir();
    in_port = 8'h0F;
    bus_write(3'd1, 32'hFFFF_FFF0);
    bus_write(3'd0, 32'h0000_005A);
    tick(); tick();
    address = 3'd0;
    #1;
    nvec++; if (oe_port !== 8'hF0) begin nerr++; $display("FAIL dir_oe_port: got %h expected f0", oe_port); end
    nvec++; if (out_port !== 8'h5A) begin nerr++; $display("FAIL data_out_port: got %h expected 5a", out_port); end
    nvec++; if (readdata !== 32'h0000005F || readdata !== exp_read(3'd0))
      begin nerr++; $display("FAIL data_mixed_read: got %h expected 0000005f", readdata); end
    address = 3'd1;
    #1;
    nvec++; if (readdata !== 32'h000000F0) begin nerr++; $display("FAIL dir_read: got %h expected 000000f0", readdata); end
  endtask

  task automatic test_edge_irq();
    in_port = 8'h00;
    repeat (4) tick();
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h01);
    address = 3'd3;
    in_port = 8'h01;
    tick(); tick();
    nvec++; if (readdata !== 32'h0 || irq !== 1'b0)
      begin nerr++; $display("FAIL edge_early: got %h/%b expected 00000000/0", readdata, irq); end
    tick();
    nvec++; if (readdata !== 32'h01 || readdata !== exp_read(3'd3))
      begin nerr++; $display("FAIL edge_capture: got %h expected 00000001", readdata); end
    nvec++; if (irq !== 1'b1) begin nerr++; $display("FAIL edge_irq: got %b expected 1", irq); end
    bus_write(3'd3, 32'h01);
    address = 3'd3;
    #1;
    nvec++; if (readdata !== 32'h0 || irq !== 1'b0)
      begin nerr++; $display("FAIL edge_clear: got %h/%b expected 00000000/0", readdata, irq); end
  endtask

  task automatic test_warmup();
    in_port = 8'hFF;
    address = 3'd3;
    do_reset();
    repeat (6) tick();
    nvec++; if (readdata !== 32'h0) begin nerr++; $display("FAIL warmup_no_capture: got %h expected 00000000", readdata); end
    in_port = 8'hF7;
    repeat (4) tick();
    in_port = 8'hFF;
    repeat (4) tick();
    nvec++; if (readdata !== 32'h08 || readdata !== exp_read(3'd3))
      begin nerr++; $display("FAIL warmup_bit3_edge: got %h expected 00000008", readdata); end
  endtask

  task automatic test_collision();
    bus_write(3'd3, 32'h08);
    address = 3'd3;
    #1;
    nvec++; if (readdata !== 32'h0) begin nerr++; $display("FAIL plain_clear: got %h expected 00000000", readdata); end
    in_port = 8'hF7;
    repeat (4) tick();
    in_port = 8'hFF;
    tick(); tick();
    bus_write(3'd3, 32'h08);
    address = 3'd3;
    #1;
    nvec++; if (readdata !== 32'h08 || readdata !== exp_read(3'd3))
      begin nerr++; $display("FAIL set_wins: got %h expected 00000008", readdata); end
  endtask

  task automatic test_bitset();
    logic [7:0] want;
`ifdef NIOS_PIO_BITSET_EN
    want = 8'h80;
`else
    want = 8'h00;
`endif
    bus_write(3'd0, 32'h00);
    bus_write(3'd4, 32'h81);
    bus_write(3'd5, 32'h01);
    nvec++; if (out_port !== want || out_port !== m_data)
      begin nerr++; $display("FAIL bitset_out_port: got %h expected %h", out_port, want); end
    for (int a = 4; a < 6; a++) begin
      address = 3'(a);
      #1;
      nvec++; if (readdata !== 32'h0) begin nerr++; $display("FAIL bitset_read%0d: got %h expected 00000000", a, readdata); end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      chipselect = ($urandom_range(0, 2) == 0);
      write_n    = ($urandom_range(0, 1) == 0);
      address    = 3'($urandom_range(0, 7));
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      #1;
      nvec++; if (readdata !== exp_read(address))
        begin nerr++; $display("FAIL rand_read a=%0d: got %h expected %h", address, readdata, exp_read(address)); end
      nvec++; if (irq !== |(m_cap & m_mask))
        begin nerr++; $display("FAIL rand_irq: got %b expected %b", irq, |(m_cap & m_mask)); end
      nvec++; if (out_port !== m_data || oe_port !== m_dir)
        begin nerr++; $display("FAIL rand_ports: got %h/%h expected %h/%h", out_port, oe_port, m_data, m_dir); end
    end
  endtask

  task automatic test_mid_reset();
    test_random(150);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd3;
    #2;
    reset_n = 1'b0;
    #1;
    nvec++; if (out_port !== 8'hA5 || oe_port !== 8'h00 || irq !== 1'b0 || readdata !== 32'h0)
      begin nerr++; $display("FAIL async_reset: got %h/%h/%b/%h expected a5/00/0/00000000", out_port, oe_port, irq, readdata); end
    model_reset();
    reset_n = 1'b1;
    test_random(150);
  endtask

  initial begin
    reset_n    = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'h00;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_data_dir();
    test_edge_irq();
    test_warmup();
    test_collision();
    test_bitset();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
